dahb_arbiter: RTL and testbench
===============================

Name: dahb_arbiter

Overview:
- Two-master to one-slave AHB3-Lite arbiter with per-master address-phase buffering.
- Lets the instruction and data ports of the core share one single-ported AHB slave (RAM or peripheral bus) without either master seeing protocol violations.
- Uncontended requests pass through with zero added wait states.
- Contended requests are captured, stalled and replayed under round-robin or fixed priority.

Parameters:
- AW, 32: address width of both master ports and the slave port.
- ROUND_ROBIN, 1: 1 = alternate winner on simultaneous requests; 0 = master 0 always wins.

Ports:
- s_clk_i  in  1  clock.
- s_resetn_i  in  1  reset; asynchronous, active-low.
- s_haddr_i[2]  in  AW  master address.
- s_hwdata_i[2]  in  32  master write data.
- s_hsize_i[2]  in  3  master transfer size.
- s_htrans_i[2]  in  2  master transfer type.
- s_hwrite_i[2]  in  1  master write flag.
- s_hsel_i[2]  in  1  master select.
- s_hrdata_o[2]  out  32  read data to each master.
- s_hready_o[2]  out  1  ready to each master.
- s_hresp_o[2]  out  1  response to each master.
- m_haddr_o  out  AW  slave address.
- m_hwdata_o  out  32  slave write data.
- m_hsize_o  out  3  slave transfer size.
- m_htrans_o  out  2  slave transfer type.
- m_hwrite_o  out  1  slave write flag.
- m_hsel_o  out  1  slave select.
- m_hmaster_o  out  1  id of the master owning the current slave address phase.
- m_hrdata_i  in  32  slave read data.
- m_hready_i  in  1  slave ready.
- m_hresp_i  in  1  slave response.

Behaviour:
- Request definition: request[k] = s_hsel_i[k] & s_htrans_i[k]==NONSEQ(2'd2) & s_hready_o[k]. IDLE, BUSY and SEQ are treated as no request.
- State per master: IDLE, PEND (address buffered: addr, size, write), DATA (owns the slave data phase).
- Global state: dph_valid/dph_id (data-phase owner) and last_grant.
- Issue rule: a slave address phase is issued only in a cycle with m_hready_i=1. Candidate order:
  - PEND masters first.
  - Then live requests.
  - Ties (both PEND, or both live) go to master !last_grant when ROUND_ROBIN=1, else master 0.
- Issued address phase: m_hsel_o=1, m_htrans_o=NONSEQ, address/size/write taken from the buffer (PEND) or from the master inputs (live); m_hmaster_o=winner.
- Winner then moves to DATA, and last_grant becomes the winner, at the clock edge.
- Live request that does not issue (it lost the tie, or m_hready_i=0) is captured into its buffer and the master moves to PEND.
- No issue: m_hsel_o=0, m_htrans_o=IDLE, m_haddr_o=0, m_hsize_o=0, m_hwrite_o=0; m_hmaster_o holds its value.
- Data-phase end: DATA owner returns to IDLE when m_hready_i=1. A new live request from the same master in that cycle is allowed (back-to-back pipelining).
- Readiness:
  - s_hready_o[k]=1 in IDLE.
  - s_hready_o[k]=0 in PEND.
  - s_hready_o[k]=m_hready_i in DATA.
- Response: s_hresp_o[k]=m_hresp_i when k is the DATA owner, else 0. The two-cycle ERROR response passes through unchanged.
- Data paths:
  - s_hrdata_o[0]=s_hrdata_o[1]=m_hrdata_i.
  - m_hwdata_o=s_hwdata_i[dph_id], or 0 when no data phase. Masters hold hwdata stable while stalled (AHB rule), so no write-data buffering.
- Latency:
  - Uncontended, slave idle: same-cycle pass-through, 0 extra waits.
  - Losing master: at least 1 extra cycle, plus the winner's data-phase length.
- Simultaneous events:
  - PEND entry plus a live request from the other master: PEND wins, the live request is buffered.
  - Both buffers full is legal; resolved by the tie rule.
- Reset (asynchronous, any time including mid-transfer):
  - All masters IDLE, buffers cleared, dph_valid=0, last_grant=1 (master 0 wins the first tie), m_hmaster_o=0.
  - s_hready_o=1, s_hresp_o=0, m_htrans_o=IDLE, m_hsel_o=0.
  - In-flight transfers are dropped; the slave is reset by the same signal.

Test Plan:
- Master 0 reads 0x100, master 1 idle, slave zero-wait → m_haddr_o=0x100 in the same cycle, m_hmaster_o=0, s_hready_o[0]=1 throughout, data returned next cycle.
- Both masters NONSEQ in the same cycle (M0 read 0x10, M1 write 0x20 data 0xDEADBEEF), ROUND_ROBIN=1, after reset:
  - M0 issued first; M1 PEND with s_hready_o[1]=0.
  - M1 issued next cycle from its buffer; slave sees write 0xDEADBEEF at 0x20.
- Repeat the simultaneous pair 4 times:
  - ROUND_ROBIN=1: winners alternate 1,0,1,0.
  - ROUND_ROBIN=0: master 0 wins all four.
- Slave inserts 3 wait states on M0's data phase while M1 requests → M1 buffered; M1 address issued in the cycle M0's m_hready_i=1; s_hready_o[1] low until M1's data phase completes.
- Slave ERROR (hresp=1, hready 0 then 1) on an M1 transfer → s_hresp_o[1] mirrors both cycles, s_hresp_o[0]=0; s_hresp_o[1]=0 afterwards.
- Assert s_resetn_i low while M0 is PEND and M1 is in DATA → immediately all s_hready_o=1, m_htrans_o=IDLE; the first post-reset tie goes to M0.

Source files
------------

// File: rtl/dahb_arbiter_if.sv
// Bus bundle between two AHB3-Lite masters, the arbiter and one AHB3-Lite slave.
// The slave modport is the arbiter's view; the master modport drives masters and slave.
// s_* signals are per-master arrays, m_* signals face the shared slave.
interface dahb_arbiter_if #(
  parameter int AW = 32
);
  logic [AW-1:0] s_haddr_i  [2];
  logic [31:0]   s_hwdata_i [2];
  logic [2:0]    s_hsize_i  [2];
  logic [1:0]    s_htrans_i [2];
  logic          s_hwrite_i [2];
  logic          s_hsel_i   [2];
  logic [31:0]   s_hrdata_o [2];
  logic          s_hready_o [2];
  logic          s_hresp_o  [2];
  logic [AW-1:0] m_haddr_o;
  logic [31:0]   m_hwdata_o;
  logic [2:0]    m_hsize_o;
  logic [1:0]    m_htrans_o;
  logic          m_hwrite_o;
  logic          m_hsel_o;
  logic          m_hmaster_o;
  logic [31:0]   m_hrdata_i;
  logic          m_hready_i;
  logic          m_hresp_i;

  modport slave (
    input  s_haddr_i, s_hwdata_i, s_hsize_i, s_htrans_i, s_hwrite_i, s_hsel_i,
    input  m_hrdata_i, m_hready_i, m_hresp_i,
    output s_hrdata_o, s_hready_o, s_hresp_o,
    output m_haddr_o, m_hwdata_o, m_hsize_o, m_htrans_o, m_hwrite_o, m_hsel_o, m_hmaster_o
  );

  modport master (
    output s_haddr_i, s_hwdata_i, s_hsize_i, s_htrans_i, s_hwrite_i, s_hsel_i,
    output m_hrdata_i, m_hready_i, m_hresp_i,
    input  s_hrdata_o, s_hready_o, s_hresp_o,
    input  m_haddr_o, m_hwdata_o, m_hsize_o, m_htrans_o, m_hwrite_o, m_hsel_o, m_hmaster_o
  );
endinterface

// File: rtl/dahb_arbiter.sv
// Two-master to one-slave AHB3-Lite arbiter with a per-master address-phase buffer.
// Latency: uncontended NONSEQ passes through in the same cycle; a loser waits >=1 cycle plus the winner's data phase.
// Backpressure: a buffered master sees hready low until its own data phase ends; slave hready gates every issue.
module dahb_arbiter #(
  parameter int AW          = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          s_clk_i,
  input  logic          s_resetn_i,
  dahb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DATA = 2'd2
  } mst_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  mst_state_t    st_q [2];
  mst_state_t    st_d [2];
  logic [AW-1:0] buf_addr_q  [2];
  logic [2:0]    buf_size_q  [2];
  logic          buf_write_q [2];
  logic          dph_valid_q, dph_valid_d;
  logic          dph_id_q, dph_id_d;
  logic          last_grant_q;
  logic          hmaster_q;
  logic [1:0]    rdy;
  logic [1:0]    req;
  logic [1:0]    pend;
  logic          issue;
  logic          win;
  logic          tie_pick;

  // Per-master readiness and live NONSEQ requests; nothing is requested while reset is held.
  always_comb begin
    rdy  = '0;
    req  = '0;
    pend = '0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = (st_q[k] == ST_PEND);
      case (st_q[k])
        ST_IDLE: rdy[k] = 1'b1;
        ST_PEND: rdy[k] = 1'b0;
        default: rdy[k] = bus.m_hready_i;
      endcase
      req[k] = s_resetn_i & bus.s_hsel_i[k] & (bus.s_htrans_i[k] == HTRANS_NONSEQ) & rdy[k];
    end
  end

  // Pick the winner: buffered masters before live ones, ties by round-robin or master 0.
  always_comb begin
    tie_pick = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    issue    = 1'b0;
    win      = 1'b0;
    if (bus.m_hready_i) begin
      if (pend != 2'b00) begin
        issue = 1'b1;
        win   = (pend == 2'b11) ? tie_pick : pend[1];
      end else if (req != 2'b00) begin
        issue = 1'b1;
        win   = (req == 2'b11) ? tie_pick : req[1];
      end
    end
  end

  // Next state per master and data-phase ownership.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_d[k] = st_q[k];
      if (issue && (win == (k == 1))) begin
        st_d[k] = ST_DATA;
      end else if (req[k]) begin
        st_d[k] = ST_PEND;
      end else if ((st_q[k] == ST_DATA) && bus.m_hready_i) begin
        st_d[k] = ST_IDLE;
      end
    end
    dph_valid_d = issue | (dph_valid_q & ~bus.m_hready_i);
    dph_id_d    = issue ? win : dph_id_q;
  end

  // State, data-phase owner, last grant and the held master id.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      st_q[0]      <= ST_IDLE;
      st_q[1]      <= ST_IDLE;
      dph_valid_q  <= 1'b0;
      dph_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      hmaster_q    <= 1'b0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      dph_valid_q <= dph_valid_d;
      dph_id_q    <= dph_id_d;
      if (issue) begin
        last_grant_q <= win;
        hmaster_q    <= win;
      end
    end
  end

  // Capture the address phase of a live request that could not be issued this cycle.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int k = 0; k < 2; k++) begin
        buf_addr_q[k]  <= '0;
        buf_size_q[k]  <= '0;
        buf_write_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (req[k] && (st_d[k] == ST_PEND)) begin
          buf_addr_q[k]  <= bus.s_haddr_i[k];
          buf_size_q[k]  <= bus.s_hsize_i[k];
          buf_write_q[k] <= bus.s_hwrite_i[k];
        end
      end
    end
  end

  // Drive the slave address phase from the buffer or the live master, and route responses back.
  always_comb begin
    bus.m_hsel_o    = 1'b0;
    bus.m_htrans_o  = HTRANS_IDLE;
    bus.m_haddr_o   = '0;
    bus.m_hsize_o   = '0;
    bus.m_hwrite_o  = 1'b0;
    bus.m_hmaster_o = hmaster_q;
    if (issue) begin
      bus.m_hsel_o    = 1'b1;
      bus.m_htrans_o  = HTRANS_NONSEQ;
      bus.m_hmaster_o = win;
      if (pend[win]) begin
        bus.m_haddr_o  = buf_addr_q[win];
        bus.m_hsize_o  = buf_size_q[win];
        bus.m_hwrite_o = buf_write_q[win];
      end else begin
        bus.m_haddr_o  = bus.s_haddr_i[win];
        bus.m_hsize_o  = bus.s_hsize_i[win];
        bus.m_hwrite_o = bus.s_hwrite_i[win];
      end
    end
    // Masters hold hwdata while stalled, so the data phase reads it straight from the owner.
    bus.m_hwdata_o = dph_valid_q ? bus.s_hwdata_i[dph_id_q] : 32'd0;
    for (int k = 0; k < 2; k++) begin
      bus.s_hready_o[k] = rdy[k];
      bus.s_hresp_o[k]  = (dph_valid_q && (dph_id_q == (k == 1))) ? bus.m_hresp_i : 1'b0;
      bus.s_hrdata_o[k] = bus.m_hrdata_i;
    end
  end

endmodule

// File: tb/tb_dahb_arbiter.sv
// Bench for dahb_arbiter: one round-robin and one fixed-priority instance share all stimulus.
// Directed table and sequences use hand-derived constants; random phase uses a transfer-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dahb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        sel   [2];
  logic [1:0]  trans [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  size  [2];
  logic        wr    [2];
  logic        hready, hresp;
  logic [31:0] rdata;

  int n_tests;
  int n_fail;

  dahb_arbiter_if #(.AW(32)) bus_rr ();
  dahb_arbiter_if #(.AW(32)) bus_fp ();

  for (genvar k = 0; k < 2; k++) begin : g_drv
    assign bus_rr.s_haddr_i[k]  = addr[k];
    assign bus_rr.s_hwdata_i[k] = wdata[k];
    assign bus_rr.s_hsize_i[k]  = size[k];
    assign bus_rr.s_htrans_i[k] = trans[k];
    assign bus_rr.s_hwrite_i[k] = wr[k];
    assign bus_rr.s_hsel_i[k]   = sel[k];
    assign bus_fp.s_haddr_i[k]  = addr[k];
    assign bus_fp.s_hwdata_i[k] = wdata[k];
    assign bus_fp.s_hsize_i[k]  = size[k];
    assign bus_fp.s_htrans_i[k] = trans[k];
    assign bus_fp.s_hwrite_i[k] = wr[k];
    assign bus_fp.s_hsel_i[k]   = sel[k];
  end
  assign bus_rr.m_hrdata_i = rdata;
  assign bus_rr.m_hready_i = hready;
  assign bus_rr.m_hresp_i  = hresp;
  assign bus_fp.m_hrdata_i = rdata;
  assign bus_fp.m_hready_i = hready;
  assign bus_fp.m_hresp_i  = hresp;

  dahb_arbiter #(.AW(32), .ROUND_ROBIN(1'b1)) dut_rr (
    .s_clk_i    (clk),
    .s_resetn_i (rstn),
    .bus        (bus_rr.slave)
  );

  dahb_arbiter #(.AW(32), .ROUND_ROBIN(1'b0)) dut_fp (
    .s_clk_i    (clk),
    .s_resetn_i (rstn),
    .bus        (bus_fp.slave)
  );

  typedef struct packed {
    logic [1:0]  trans;
    logic        sel;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic        mst;
    logic [31:0] wd;
    logic [1:0]  rdy;
    logic [1:0]  resp;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } obs_t;

  function automatic obs_t get_obs(input int m);
    obs_t o;
    if (m == 0) begin
      o.trans = bus_rr.m_htrans_o;  o.sel = bus_rr.m_hsel_o;     o.addr = bus_rr.m_haddr_o;
      o.size  = bus_rr.m_hsize_o;   o.wr  = bus_rr.m_hwrite_o;   o.mst  = bus_rr.m_hmaster_o;
      o.wd    = bus_rr.m_hwdata_o;
      o.rdy   = {bus_rr.s_hready_o[1], bus_rr.s_hready_o[0]};
      o.resp  = {bus_rr.s_hresp_o[1], bus_rr.s_hresp_o[0]};
      o.rd0   = bus_rr.s_hrdata_o[0]; o.rd1 = bus_rr.s_hrdata_o[1];
    end else begin
      o.trans = bus_fp.m_htrans_o;  o.sel = bus_fp.m_hsel_o;     o.addr = bus_fp.m_haddr_o;
      o.size  = bus_fp.m_hsize_o;   o.wr  = bus_fp.m_hwrite_o;   o.mst  = bus_fp.m_hmaster_o;
      o.wd    = bus_fp.m_hwdata_o;
      o.rdy   = {bus_fp.s_hready_o[1], bus_fp.s_hready_o[0]};
      o.resp  = {bus_fp.s_hresp_o[1], bus_fp.s_hresp_o[0]};
      o.rd0   = bus_fp.s_hrdata_o[0]; o.rd1 = bus_fp.s_hrdata_o[1];
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s_%s: got 0x%0h, expected 0x%0h at %0t", nm, (m == 0) ? "rr" : "fp", act, exp, $time);
    end
  endtask

  task automatic set_m(input int k, input bit on, input logic [31:0] a, input bit w);
    sel[k]   = on;
    trans[k] = on ? 2'd2 : 2'd0;
    addr[k]  = a;
    wr[k]    = w;
    size[k]  = 3'd2;
  endtask

  task automatic idle_inputs();
    set_m(0, 1'b0, 32'd0, 1'b0);
    set_m(1, 1'b0, 32'd0, 1'b0);
    wdata[0] = 32'd0;
    wdata[1] = 32'd0;
    hready   = 1'b1;
    hresp    = 1'b0;
    rdata    = 32'd0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Transfer-level reference model: who is waiting, who owns the data phase, who was granted last.
  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  sz;
    logic        w;
  } xfer_t;

  int    own   [2];
  int    lastg [2];
  int    hm    [2];
  bit    waiting [2][2];
  xfer_t held    [2][2];

  task automatic mdl_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1; lastg[m] = 1; hm[m] = 0;
      waiting[m][0] = 1'b0; waiting[m][1] = 1'b0;
    end
  endtask

  task automatic mdl_check_step(input int m);
    bit    ready [2];
    bit    wants [2];
    bit    cand  [2];
    bit    any_wait, go;
    int    ncand, pick;
    obs_t  e, o;
    for (int k = 0; k < 2; k++) begin
      ready[k] = waiting[m][k] ? 1'b0 : ((own[m] == k) ? hready : 1'b1);
      wants[k] = rstn && sel[k] && (trans[k] == 2'd2) && ready[k];
    end
    any_wait = waiting[m][0] | waiting[m][1];
    for (int k = 0; k < 2; k++) cand[k] = any_wait ? waiting[m][k] : wants[k];
    ncand = int'(cand[0]) + int'(cand[1]);
    go    = hready && (ncand > 0);
    if (ncand == 2) pick = (m == 0) ? (1 - lastg[m]) : 0;
    else            pick = cand[1] ? 1 : 0;
    e = '0;
    if (go) begin
      e.trans = 2'd2;
      e.sel   = 1'b1;
      if (waiting[m][pick]) begin
        e.addr = held[m][pick].a; e.size = held[m][pick].sz; e.wr = held[m][pick].w;
      end else begin
        e.addr = addr[pick]; e.size = size[pick]; e.wr = wr[pick];
      end
    end
    e.mst  = go ? (pick == 1) : (hm[m] == 1);
    e.wd   = (own[m] >= 0) ? wdata[own[m]] : 32'd0;
    e.rdy  = {ready[1], ready[0]};
    e.resp = {(own[m] == 1) & hresp, (own[m] == 0) & hresp};
    e.rd0  = rdata;
    e.rd1  = rdata;
    o = get_obs(m);
    chk("rnd_htrans", m, 32'(o.trans), 32'(e.trans));
    chk("rnd_hsel",   m, 32'(o.sel),   32'(e.sel));
    chk("rnd_haddr",  m, o.addr,       e.addr);
    chk("rnd_hsize",  m, 32'(o.size),  32'(e.size));
    chk("rnd_hwrite", m, 32'(o.wr),    32'(e.wr));
    chk("rnd_hmaster",m, 32'(o.mst),   32'(e.mst));
    chk("rnd_hwdata", m, o.wd,         e.wd);
    chk("rnd_hready", m, 32'(o.rdy),   32'(e.rdy));
    chk("rnd_hresp",  m, 32'(o.resp),  32'(e.resp));
    chk("rnd_hrdata", m, o.rd0 ^ o.rd1 ^ o.rd0, e.rd0);
    chk("rnd_hrdata1",m, o.rd1,        e.rd1);
    // Advance to the next cycle.
    for (int k = 0; k < 2; k++) begin
      if (wants[k] && !(go && (pick == k))) begin
        waiting[m][k] = 1'b1;
        held[m][k]    = '{a: addr[k], sz: size[k], w: wr[k]};
      end
    end
    if (go) begin
      waiting[m][pick] = 1'b0;
      own[m] = pick; lastg[m] = pick; hm[m] = pick;
    end else if (hready) begin
      own[m] = -1;
    end
  endtask

  typedef struct {
    bit          s0;
    logic [31:0] a0;
    bit          s1;
    bit          w1;
    logic [31:0] a1;
    bit          hr;
    bit          hp;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    bit          e_mst;
    bit          e_wr;
    logic [1:0]  e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(bit s0, logic [31:0] a0, bit s1, bit w1, logic [31:0] a1, bit hr, bit hp,
                              logic [1:0] et, logic [31:0] ea, bit em, bit ew, logic [1:0] er,
                              logic [1:0] ep, logic [31:0] ed);
    vec_t v;
    v.s0 = s0; v.a0 = a0; v.s1 = s1; v.w1 = w1; v.a1 = a1; v.hr = hr; v.hp = hp;
    v.e_trans = et; v.e_addr = ea; v.e_mst = em; v.e_wr = ew; v.e_rdy = er; v.e_resp = ep; v.e_wd = ed;
    return v;
  endfunction

  vec_t tbl [16];
  obs_t o;
  bit   exp_w;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rstn = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      o = get_obs(m);
      chk("rst_hready", m, 32'(o.rdy), 32'd3);
      chk("rst_htrans", m, 32'(o.trans), 32'd0);
      chk("rst_hsel", m, 32'(o.sel), 32'd0);
      chk("rst_hmaster", m, 32'(o.mst), 32'd0);
      chk("rst_hresp", m, 32'(o.resp), 32'd0);
    end
    next_cycle();
    rstn = 1'b1;

    // Cycle-by-cycle table: simultaneous pair, lone read, 3 wait states, ERROR response.
    tbl[0]  = mk(1, 32'h10,  1, 1, 32'h20,  1, 0, 2'd2, 32'h10,  0, 0, 2'b11, 2'b00, 32'h0);
    tbl[1]  = mk(0, 32'h0,   1, 1, 32'h20,  1, 0, 2'd2, 32'h20,  1, 1, 2'b01, 2'b00, 32'h0);
    tbl[2]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 2'd0, 32'h0,   1, 0, 2'b11, 2'b00, 32'hDEADBEEF);
    tbl[3]  = mk(1, 32'h100, 0, 0, 32'h0,   1, 0, 2'd2, 32'h100, 0, 0, 2'b11, 2'b00, 32'h0);
    tbl[4]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 2'd0, 32'h0,   0, 0, 2'b11, 2'b00, 32'h0);
    tbl[5]  = mk(1, 32'h200, 0, 0, 32'h0,   1, 0, 2'd2, 32'h200, 0, 0, 2'b11, 2'b00, 32'h0);
    tbl[6]  = mk(0, 32'h0,   1, 0, 32'h300, 0, 0, 2'd0, 32'h0,   0, 0, 2'b10, 2'b00, 32'h0);
    tbl[7]  = mk(0, 32'h0,   1, 0, 32'h300, 0, 0, 2'd0, 32'h0,   0, 0, 2'b00, 2'b00, 32'h0);
    tbl[8]  = mk(0, 32'h0,   1, 0, 32'h300, 0, 0, 2'd0, 32'h0,   0, 0, 2'b00, 2'b00, 32'h0);
    tbl[9]  = mk(0, 32'h0,   1, 0, 32'h300, 1, 0, 2'd2, 32'h300, 1, 0, 2'b01, 2'b00, 32'h0);
    tbl[10] = mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 2'd0, 32'h0,   1, 0, 2'b01, 2'b00, 32'hDEADBEEF);
    tbl[11] = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 2'd0, 32'h0,   1, 0, 2'b11, 2'b00, 32'hDEADBEEF);
    tbl[12] = mk(0, 32'h0,   1, 0, 32'h400, 1, 0, 2'd2, 32'h400, 1, 0, 2'b11, 2'b00, 32'h0);
    tbl[13] = mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 2'd0, 32'h0,   1, 0, 2'b01, 2'b10, 32'hDEADBEEF);
    tbl[14] = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 2'd0, 32'h0,   1, 0, 2'b11, 2'b10, 32'hDEADBEEF);
    tbl[15] = mk(0, 32'h0,   0, 0, 32'h0,   1, 0, 2'd0, 32'h0,   1, 0, 2'b11, 2'b00, 32'h0);

    wdata[0] = 32'h0;
    wdata[1] = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      set_m(0, tbl[i].s0, tbl[i].a0, 1'b0);
      set_m(1, tbl[i].s1, tbl[i].a1, tbl[i].w1);
      hready = tbl[i].hr;
      hresp  = tbl[i].hp;
      rdata  = 32'hA5A50000 + 32'(i);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        o = get_obs(m);
        chk($sformatf("tbl%0d_htrans", i), m, 32'(o.trans), 32'(tbl[i].e_trans));
        chk($sformatf("tbl%0d_haddr", i), m, o.addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_hmaster", i), m, 32'(o.mst), 32'(tbl[i].e_mst));
        chk($sformatf("tbl%0d_hwrite", i), m, 32'(o.wr), 32'(tbl[i].e_wr));
        chk($sformatf("tbl%0d_hready", i), m, 32'(o.rdy), 32'(tbl[i].e_rdy));
        chk($sformatf("tbl%0d_hresp", i), m, 32'(o.resp), 32'(tbl[i].e_resp));
        chk($sformatf("tbl%0d_hwdata", i), m, o.wd, tbl[i].e_wd);
        chk($sformatf("tbl%0d_hrdata", i), m, o.rd0, 32'hA5A50000 + 32'(i));
      end
      next_cycle();
    end

    // Four simultaneous pairs; the tie winner re-requests while the loser replays.
    do_reset();
    set_m(0, 1'b1, 32'h80, 1'b0);
    @(negedge clk);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    next_cycle();
    for (int r = 0; r < 4; r++) begin
      exp_w = ((r % 2) == 0);
      set_m(0, 1'b1, 32'h10, 1'b0);
      set_m(1, 1'b1, 32'h20, 1'b1);
      @(negedge clk);
      chk($sformatf("pair%0d_tie_winner", r), 0, 32'(bus_rr.m_hmaster_o), 32'(exp_w));
      chk($sformatf("pair%0d_tie_winner", r), 1, 32'(bus_fp.m_hmaster_o), 32'd0);
      next_cycle();
      @(negedge clk);
      chk($sformatf("pair%0d_replay", r), 0, 32'(bus_rr.m_hmaster_o), 32'(!exp_w));
      chk($sformatf("pair%0d_replay", r), 1, 32'(bus_fp.m_hmaster_o), 32'd1);
      chk($sformatf("pair%0d_replay_htrans", r), 0, 32'(bus_rr.m_htrans_o), 32'd2);
      next_cycle();
      set_m(0, 1'b0, 32'h0, 1'b0);
      set_m(1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("pair%0d_rerequest", r), 0, 32'(bus_rr.m_hmaster_o), 32'(exp_w));
      chk($sformatf("pair%0d_rerequest", r), 1, 32'(bus_fp.m_hmaster_o), 32'd0);
      next_cycle();
      @(negedge clk);
      next_cycle();
    end

    // Asynchronous reset while M0 is buffered and M1 owns a stalled ERROR data phase.
    do_reset();
    set_m(1, 1'b1, 32'h40, 1'b0);
    @(negedge clk);
    chk("prerst_m1_issue", 0, 32'(bus_rr.m_hmaster_o), 32'd1);
    chk("prerst_m1_issue", 1, 32'(bus_fp.m_hmaster_o), 32'd1);
    next_cycle();
    set_m(1, 1'b0, 32'h0, 1'b0);
    set_m(0, 1'b1, 32'h50, 1'b0);
    hready = 1'b0;
    @(negedge clk);
    next_cycle();
    hresp = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      o = get_obs(m);
      chk("prerst_hready", m, 32'(o.rdy), 32'd0);
      chk("prerst_hresp", m, 32'(o.resp), 32'b10);
    end
    #1 rstn = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      o = get_obs(m);
      chk("inrst_hready", m, 32'(o.rdy), 32'd3);
      chk("inrst_htrans", m, 32'(o.trans), 32'd0);
      chk("inrst_hsel", m, 32'(o.sel), 32'd0);
      chk("inrst_hresp", m, 32'(o.resp), 32'd0);
      chk("inrst_hmaster", m, 32'(o.mst), 32'd0);
    end
    next_cycle();
    rstn = 1'b1;
    set_m(0, 1'b1, 32'h10, 1'b0);
    set_m(1, 1'b1, 32'h20, 1'b1);
    hready = 1'b1;
    hresp  = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      o = get_obs(m);
      chk("postrst_tie_hmaster", m, 32'(o.mst), 32'd0);
      chk("postrst_tie_haddr", m, o.addr, 32'h10);
    end
    next_cycle();

    // Random stimulus against the transfer-level model.
    do_reset();
    mdl_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        sel[k]   = ($urandom_range(0, 3) != 0);
        trans[k] = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom_range(0, 3));
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        size[k]  = 3'($urandom_range(0, 7));
        wr[k]    = 1'($urandom_range(0, 1));
      end
      hready = ($urandom_range(0, 3) != 0);
      hresp  = ($urandom_range(0, 7) == 0);
      rdata  = $urandom;
      @(negedge clk);
      mdl_check_step(0);
      mdl_check_step(1);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
